// File: rtl/tnn_feature_packer.sv
// tnn_feature_packer
// Producer side of the 2-bit TNN feature interface. Raw samples arrive one
// feature per beat, each is quantized to 2 bits against three thresholds, and
// N_FEAT of them are packed into one vector held under a valid/ready handshake.
// Framing errors (short or long samples) raise a one-cycle err_frame pulse and
// drop the offending sample; a long sample is drained up to its s_last beat.

module tnn_feature_packer #(
    parameter int RAW_W  = 8,
    parameter int N_FEAT = 6,
    parameter int T1     = 64,
    parameter int T2     = 128,
    parameter int T3     = 192
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [RAW_W-1:0]      s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [2*N_FEAT-1:0]   m_feat,
    output logic                  err_frame,
    output logic [15:0]           sample_cnt
);

    localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HOLD    = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [IDX_W-1:0]       idx;
    logic [2*N_FEAT-1:0]    feat_buf;
    logic [2*N_FEAT-1:0]    vec_next;
    logic [1:0]             q;
    logic                   beat;
    logic                   at_end;
    logic                   collect_beat;
    logic                   frame_ok;
    logic                   frame_bad;

    // Thresholds are unsigned and assumed ordered T1 <= T2 <= T3; the
    // highest threshold reached decides the code.
    function automatic logic [1:0] quantize(input logic [RAW_W-1:0] d);
        if (d >= RAW_W'(T3))
            return 2'd3;
        else if (d >= RAW_W'(T2))
            return 2'd2;
        else if (d >= RAW_W'(T1))
            return 2'd1;
        else
            return 2'd0;
    endfunction

    // Beat decode: a transfer happens on valid & ready; the slot position and
    // s_last together classify it as a good end, short end or overrun.
    always_comb begin
        q            = quantize(s_data);
        beat         = s_valid & s_ready;
        at_end       = (idx == LAST_IDX);
        collect_beat = (state == COLLECT) & beat;
        frame_ok     = collect_beat & at_end & s_last;
        frame_bad    = collect_beat & (at_end != s_last);
    end

    // Vector presented on entry to HOLD: stored slots plus the final beat's
    // code written straight into the top slot.
    always_comb begin
        vec_next                      = feat_buf;
        vec_next[2*(N_FEAT-1) +: 2]   = q;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= COLLECT;
        else
            state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            COLLECT: begin
                if (collect_beat && at_end)
                    next_state = s_last ? HOLD : DRAIN;
            end
            HOLD: begin
                if (m_ready)
                    next_state = COLLECT;
            end
            DRAIN: begin
                if (beat && s_last)
                    next_state = COLLECT;
            end
            default: next_state = COLLECT;
        endcase
    end

    // Handshake outputs decoded from state; HOLD blocks new beats so a beat
    // offered alongside m_ready is taken only on the following cycle.
    always_comb begin
        s_ready = 1'b1;
        m_valid = 1'b0;
        case (state)
            COLLECT: begin
                s_ready = 1'b1;
                m_valid = 1'b0;
            end
            HOLD: begin
                s_ready = 1'b0;
                m_valid = 1'b1;
            end
            DRAIN: begin
                s_ready = 1'b1;
                m_valid = 1'b0;
            end
            default: begin
                s_ready = 1'b1;
                m_valid = 1'b0;
            end
        endcase
    end

    // Slot index, error pulse, output vector and delivery counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx        <= '0;
            err_frame  <= 1'b0;
            m_feat     <= '0;
            sample_cnt <= '0;
        end else begin
            err_frame <= frame_bad;
            if (collect_beat) begin
                if (at_end || s_last)
                    idx <= '0;
                else
                    idx <= idx + IDX_W'(1);
            end
            if (frame_ok)
                m_feat <= vec_next;
            if ((state == HOLD) && m_ready)
                sample_cnt <= sample_cnt + 16'd1;
        end
    end

    // Slot storage needs no reset: every slot is rewritten before a sample
    // can reach HOLD, so stale codes never escape.
    always_ff @(posedge clk) begin
        if (collect_beat) begin
            for (int k = 0; k < N_FEAT; k++) begin
                if (idx == IDX_W'(k))
                    feat_buf[2*k +: 2] <= q;
            end
        end
    end

endmodule

// File: tb/tb_tnn_feature_packer.sv
// Testbench for tnn_feature_packer: randomized and directed frames, a
// frame-level reference model feeding an expected-vector queue, and an
// independent monitor that pops and compares on every delivered vector.

module tb_tnn_feature_packer;

    localparam int RAW_W  = 8;
    localparam int N_FEAT = 6;
    localparam int T1     = 64;
    localparam int T2     = 128;
    localparam int T3     = 192;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                s_valid;
    logic                s_ready;
    logic [RAW_W-1:0]    s_data;
    logic                s_last;
    logic                m_valid;
    logic                m_ready;
    logic [2*N_FEAT-1:0] m_feat;
    logic                err_frame;
    logic [15:0]         sample_cnt;

    int tests = 0;
    int fails = 0;

    logic [2*N_FEAT-1:0] exp_q[$];
    logic [15:0]         exp_cnt = 16'd0;
    int                  err_exp  = 0;
    int                  err_seen = 0;
    int                  ready_mode = 2;   // 0: always ready, 1: random, 2: held low
    logic                hold_prev = 1'b0;
    logic [2*N_FEAT-1:0] prev_feat = '0;
    int                  fr[$];

    tnn_feature_packer #(
        .RAW_W (RAW_W),
        .N_FEAT(N_FEAT),
        .T1    (T1),
        .T2    (T2),
        .T3    (T3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_feat    (m_feat),
        .err_frame (err_frame),
        .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference quantizer: number of thresholds the value reaches.
    function automatic int qval(input int d);
        int r = 0;
        if (d >= T1) r++;
        if (d >= T2) r++;
        if (d >= T3) r++;
        return r;
    endfunction

    // Frame-level model: a frame (beats up to s_last) of exactly N_FEAT
    // beats yields one vector; any other length yields one framing error.
    task automatic model_frame(input int beats[$]);
        logic [2*N_FEAT-1:0] v;
        if (beats.size() == N_FEAT) begin
            v = '0;
            for (int k = 0; k < N_FEAT; k++)
                v = v | ((2*N_FEAT)'(qval(beats[k])) << (2*k));
            exp_q.push_back(v);
        end else begin
            err_exp++;
        end
    endtask

    task automatic send_beat(input int d, input logic l);
        logic ok;
        ok      = 1'b0;
        s_valid = 1'b1;
        s_data  = RAW_W'(d);
        s_last  = l;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok)
            check("s_ready_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input int beats[$], input int gap_max);
        int g;
        model_frame(beats);
        for (int i = 0; i < beats.size(); i++) begin
            send_beat(beats[i], i == beats.size() - 1);
            g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            if (g > 0) begin
                repeat (g) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_idle(input string name);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !m_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok)
            check({name, "_drain_timeout"}, 32'(ok), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check({name, "_err_count"}, 32'(err_seen), 32'(err_exp));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_m_valid"},    32'(m_valid),    32'd0);
        check({name, "_s_ready"},    32'(s_ready),    32'd1);
        check({name, "_m_feat"},     32'(m_feat),     32'd0);
        check({name, "_err_frame"},  32'(err_frame),  32'd0);
        check({name, "_sample_cnt"}, 32'(sample_cnt), 32'd0);
    endtask

    // m_ready driver, updated just after each rising edge.
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Monitor: sampled on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_prev = 1'b0;
            end else begin
                if (err_frame)
                    err_seen++;
                if (m_valid) begin
                    check("s_ready_in_hold", 32'(s_ready), 32'd0);
                    if (hold_prev)
                        check("m_feat_stable", 32'(m_feat), 32'(prev_feat));
                    if (m_ready) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_vector", 32'd1, 32'd0);
                        end else begin
                            check("m_feat", 32'(m_feat), 32'(exp_q.pop_front()));
                            check("sample_cnt", 32'(sample_cnt), 32'(exp_cnt));
                            exp_cnt = exp_cnt + 16'd1;
                        end
                        hold_prev = 1'b0;
                    end else begin
                        hold_prev = 1'b1;
                        prev_feat = m_feat;
                    end
                end else begin
                    hold_prev = 1'b0;
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Stimulus.
    initial begin
        int len;
        int b[$];
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        // Basic sample, 1-cycle latency, single-cycle m_valid.
        fr = {10, 70, 130, 200, 63, 255};
        send_frame(fr, 0);
        check("t1_latency", 32'(m_valid), 32'd1);
        check("t1_m_feat", 32'(m_feat), 32'b11_00_11_10_01_00);
        @(posedge clk);
        #1;
        check("t1_m_valid_drop", 32'(m_valid), 32'd0);
        check("t1_sample_cnt", 32'(sample_cnt), 32'd1);
        wait_idle("t1");

        // Backpressure: vector held five cycles while the next sample waits.
        ready_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        send_frame(fr, 0);
        fork
            begin
                b = {200, 150, 100, 50, 0, 192};
                send_frame(b, 0);
            end
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("t2_m_valid_held", 32'(m_valid), 32'd1);
                    check("t2_s_ready_low", 32'(s_ready), 32'd0);
                    check("t2_m_feat_held", 32'(m_feat), 32'b11_00_11_10_01_00);
                end
                ready_mode = 0;
            end
        join
        wait_idle("t2");
        check("t2_sample_cnt", 32'(sample_cnt), 32'd3);

        // Short sample then a good one.
        fr = {20, 100, 250};
        send_frame(fr, 0);
        wait_idle("t3_short");
        check("t3_no_vector_cnt", 32'(sample_cnt), 32'd3);
        fr = {255, 0, 64, 128, 192, 1};
        send_frame(fr, 0);
        wait_idle("t3_after");

        // Long sample drained, then a good one.
        fr = {1, 2, 3, 4, 5, 6, 7, 8};
        send_frame(fr, 0);
        wait_idle("t4_long");
        check("t4_no_vector_cnt", 32'(sample_cnt), 32'd4);
        fr = {66, 130, 194, 10, 99, 180};
        send_frame(fr, 1);
        wait_idle("t4_after");

        // Reset mid-sample: partial beats discarded.
        for (int i = 0; i < 4; i++)
            send_beat(250, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_cnt = 16'd0;
        check_reset_outputs("t5_reset");
        fr = {0, 64, 0, 64, 0, 64};
        send_frame(fr, 0);
        check("t5_m_feat", 32'(m_feat), 32'b01_00_01_00_01_00);
        wait_idle("t5");
        check("t5_sample_cnt", 32'(sample_cnt), 32'd1);

        // Threshold boundaries.
        fr = {63, 64, 127, 128, 191, 192};
        send_frame(fr, 0);
        check("t6_boundaries", 32'(m_feat), 32'b11_10_10_01_01_00);
        wait_idle("t6");

        // Random frames with random backpressure and gaps.
        ready_mode = 1;
        for (int f = 0; f < 40; f++) begin
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : N_FEAT;
            b.delete();
            for (int i = 0; i < len; i++)
                b.push_back(int'($urandom_range(0, 255)));
            send_frame(b, 2);
        end
        ready_mode = 0;
        wait_idle("random");

        // Counter wrap: preload near the top, then deliver two vectors.
        @(negedge clk);
        force dut.sample_cnt = 16'hFFFE;
        exp_cnt = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.sample_cnt;
        fr = {5, 80, 140, 210, 30, 90};
        send_frame(fr, 0);
        send_frame(fr, 0);
        wait_idle("wrap");
        check("wrap_sample_cnt", 32'(sample_cnt), 32'd0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
